// File: rtl/tb_ahb_mtimer.sv
// AHB-Lite timer and software-interrupt slave: a prescaled 64-bit mtime, a 64-bit
// mtimecmp comparator driving timer_irq, and a 2-bit MSIP register driving soft_irq.
module tb_ahb_mtimer #(
  parameter int          W_ADDR         = 16,
  parameter logic [31:0] PRESCALE_RESET = 32'd0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ahbls_hready,
  output logic              ahbls_hready_resp,
  output logic              ahbls_hresp,
  input  logic [W_ADDR-1:0] ahbls_haddr,
  input  logic              ahbls_hwrite,
  input  logic [1:0]        ahbls_htrans,
  input  logic [2:0]        ahbls_hsize,
  input  logic [31:0]       ahbls_hwdata,
  output logic [31:0]       ahbls_hrdata,
  output logic              timer_irq,
  output logic [1:0]        soft_irq
);

  localparam logic [2:0] A_CTRL      = 3'd0;
  localparam logic [2:0] A_PRESCALE  = 3'd1;
  localparam logic [2:0] A_MTIME     = 3'd2;
  localparam logic [2:0] A_MTIMEH    = 3'd3;
  localparam logic [2:0] A_MTIMECMP  = 3'd4;
  localparam logic [2:0] A_MTIMECMPH = 3'd5;
  localparam logic [2:0] A_MSIP      = 3'd6;

  logic        acc_p0;
  logic        err_p0;
  logic        vld_p1;
  logic        write_p1;
  logic        err_p1;
  logic        err2_p1;
  logic [2:0]  addr_p1;
  logic        err_dp;
  logic        wr_en;
  logic        rd_en;
  logic        tick;
  logic        en;
  logic [31:0] prescale;
  logic [31:0] presc_cnt;
  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic [1:0]  msip;
  logic        unused_bits;

  // Only haddr[4:2] is decoded; htrans[0] only distinguishes SEQ from NONSEQ.
  assign unused_bits = ^{ahbls_htrans[0], ahbls_haddr[W_ADDR-1:5]};

  // Address phase (p0) -> data phase (p1)
  assign acc_p0 = ahbls_hready && ahbls_htrans[1];
  assign err_p0 = (ahbls_hsize != 3'd2) || (ahbls_haddr[1:0] != 2'b00) ||
                  (ahbls_haddr[4:2] == 3'd7);

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      err2_p1 <= 1'b0;
    end else if (ahbls_hready) begin
      vld_p1  <= acc_p0;
      err2_p1 <= 1'b0;
    end else if (vld_p1 && err_p1) begin
      err2_p1 <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (ahbls_hready) begin
      write_p1 <= ahbls_hwrite;
      err_p1   <= err_p0;
      addr_p1  <= ahbls_haddr[4:2];
    end
  end

  // Error responses stall one cycle with hresp high, then complete with hresp still high.
  assign err_dp            = vld_p1 && err_p1;
  assign ahbls_hresp       = err_dp;
  assign ahbls_hready_resp = !(err_dp && !err2_p1);
  assign wr_en             = vld_p1 && write_p1 && !err_p1 && ahbls_hready;
  assign rd_en             = vld_p1 && !write_p1 && !err_p1;

  always_comb begin
    ahbls_hrdata = 32'd0;
    if (rd_en) begin
      case (addr_p1)
        A_CTRL:      ahbls_hrdata = {31'd0, en};
        A_PRESCALE:  ahbls_hrdata = prescale;
        A_MTIME:     ahbls_hrdata = mtime[31:0];
        A_MTIMEH:    ahbls_hrdata = mtime[63:32];
        A_MTIMECMP:  ahbls_hrdata = mtimecmp[31:0];
        A_MTIMECMPH: ahbls_hrdata = mtimecmp[63:32];
        A_MSIP:      ahbls_hrdata = {30'd0, msip};
        default:     ahbls_hrdata = 32'd0;
      endcase
    end
  end

  assign tick = en && (presc_cnt == prescale);

  // Register file, prescaler and comparator; a software write to either mtime half drops that cycle's tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      en        <= 1'b1;
      prescale  <= PRESCALE_RESET;
      presc_cnt <= 32'd0;
      mtime     <= 64'd0;
      mtimecmp  <= 64'hffff_ffff_ffff_ffff;
      msip      <= 2'b00;
      timer_irq <= 1'b0;
    end else begin
      if (wr_en && addr_p1 == A_PRESCALE) begin
        presc_cnt <= 32'd0;
      end else if (en) begin
        presc_cnt <= tick ? 32'd0 : presc_cnt + 32'd1;
      end

      if (wr_en && addr_p1 == A_MTIME) begin
        mtime[31:0] <= ahbls_hwdata;
      end else if (wr_en && addr_p1 == A_MTIMEH) begin
        mtime[63:32] <= ahbls_hwdata;
      end else if (tick) begin
        mtime <= mtime + 64'd1;
      end

      timer_irq <= (mtime >= mtimecmp);

      if (wr_en) begin
        case (addr_p1)
          A_CTRL:      en              <= ahbls_hwdata[0];
          A_PRESCALE:  prescale        <= ahbls_hwdata;
          A_MTIMECMP:  mtimecmp[31:0]  <= ahbls_hwdata;
          A_MTIMECMPH: mtimecmp[63:32] <= ahbls_hwdata;
          A_MSIP:      msip            <= ahbls_hwdata[1:0];
          default:     ;
        endcase
      end
    end
  end

  assign soft_irq = msip;

endmodule

// File: tb/tb_tb_ahb_mtimer.sv
// Bench for tb_ahb_mtimer: a driver issues pipelined AHB transfers and pushes predicted
// responses from a register-level reference model; a monitor pops and compares them.
module tb_tb_ahb_mtimer;

  localparam logic [31:0] PRESC_RST = 32'd0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hready;
  logic        hready_resp;
  logic        hresp;
  logic [15:0] haddr = 16'h0;
  logic        hwrite = 1'b0;
  logic [1:0]  htrans = 2'b00;
  logic [2:0]  hsize = 3'd2;
  logic [31:0] hwdata = 32'h0;
  logic [31:0] hrdata;
  logic        timer_irq;
  logic [1:0]  soft_irq;

  assign hready = hready_resp;
  always #5 clk = ~clk;

  tb_ahb_mtimer #(.W_ADDR(16), .PRESCALE_RESET(PRESC_RST)) dut (
    .clk(clk), .rst(rst), .ahbls_hready(hready), .ahbls_hready_resp(hready_resp),
    .ahbls_hresp(hresp), .ahbls_haddr(haddr), .ahbls_hwrite(hwrite),
    .ahbls_htrans(htrans), .ahbls_hsize(hsize), .ahbls_hwdata(hwdata),
    .ahbls_hrdata(hrdata), .timer_irq(timer_irq), .soft_irq(soft_irq)
  );

  typedef struct packed {
    logic        v;
    logic        w;
    logic        err;
    logic [2:0]  idx;
    logic [31:0] wd;
  } xfer_t;

  typedef struct packed {
    logic        err;
    logic        chk;
    logic [31:0] data;
  } resp_t;

  resp_t      exp_q[$];
  logic [2:0] irq_q[$];
  int         checks = 0;
  int         errors = 0;
  logic       mon_en = 1'b0;

  // Reference model: architectural register values as software sees them.
  logic        m_en;
  logic [31:0] m_presc;
  logic [31:0] m_cnt;
  logic [63:0] m_mtime;
  logic [63:0] m_cmp;
  logic [1:0]  m_msip;
  logic        m_irq;
  xfer_t       dp;
  logic        dp_err2;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic model_reset();
    m_en = 1'b1; m_presc = PRESC_RST; m_cnt = 32'd0; m_mtime = 64'd0;
    m_cmp = 64'hffff_ffff_ffff_ffff; m_msip = 2'b00; m_irq = 1'b0;
    dp = '0; dp_err2 = 1'b0;
  endtask

  function automatic logic [31:0] model_rd(input logic [2:0] idx);
    case (idx)
      3'd0:    return {31'd0, m_en};
      3'd1:    return m_presc;
      3'd2:    return m_mtime[31:0];
      3'd3:    return m_mtime[63:32];
      3'd4:    return m_cmp[31:0];
      3'd5:    return m_cmp[63:32];
      3'd6:    return {30'd0, m_msip};
      default: return 32'd0;
    endcase
  endfunction

  // One bus cycle: drive address phase ap and the data of the transfer already in data phase.
  task automatic step(input xfer_t ap, input logic [15:0] a, input logic [2:0] sz, input logic r);
    logic        tick;
    logic        n_irq;
    logic [63:0] n_mtime;
    @(posedge clk); #1;
    rst    = r;
    mon_en = 1'b1;
    htrans = ap.v ? 2'b10 : 2'b00;
    haddr  = a;
    hwrite = ap.w;
    hsize  = sz;
    hwdata = dp.wd;
    irq_q.push_back({m_irq, m_msip});
    if (dp.v && !(dp.err && dp_err2))
      exp_q.push_back({dp.err, ~dp.w & ~dp.err, (dp.err ? 32'd0 : model_rd(dp.idx))});
    if (r) begin
      model_reset();
      return;
    end
    n_irq   = (m_mtime >= m_cmp);
    tick    = m_en && (m_cnt == m_presc);
    n_mtime = tick ? m_mtime + 64'd1 : m_mtime;
    if (m_en) m_cnt = tick ? 32'd0 : m_cnt + 32'd1;
    if (dp.v && dp.w && !dp.err) begin
      case (dp.idx)
        3'd0: m_en = dp.wd[0];
        3'd1: begin m_presc = dp.wd; m_cnt = 32'd0; end
        3'd2: n_mtime = {m_mtime[63:32], dp.wd};
        3'd3: n_mtime = {dp.wd, m_mtime[31:0]};
        3'd4: m_cmp[31:0] = dp.wd;
        3'd5: m_cmp[63:32] = dp.wd;
        3'd6: m_msip = dp.wd[1:0];
        default: ;
      endcase
    end
    m_mtime = n_mtime;
    m_irq   = n_irq;
    if (dp.v && dp.err && !dp_err2) begin
      dp_err2 = 1'b1;
    end else begin
      dp      = ap;
      dp_err2 = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, 16'h0, 3'd2, 1'b0);
  endtask

  function automatic xfer_t mk(input logic [15:0] a, input logic w, input logic [2:0] sz,
                               input logic [31:0] wd);
    xfer_t x;
    x.v   = 1'b1;
    x.w   = w;
    x.idx = a[4:2];
    x.wd  = wd;
    x.err = (sz != 3'd2) || (a[1:0] != 2'b00) || (a[4:2] == 3'd7);
    return x;
  endfunction

  task automatic xfer(input logic [15:0] a, input logic w, input logic [2:0] sz,
                      input logic [31:0] wd);
    xfer_t x;
    x = mk(a, w, sz, wd);
    step(x, a, sz, 1'b0);
    if (x.err) idle(2);
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] wd);
    xfer(a, 1'b1, 3'd2, wd);
  endtask

  task automatic rd(input logic [15:0] a);
    xfer(a, 1'b0, 3'd2, 32'd0);
  endtask

  task automatic rd_all();
    for (int i = 0; i < 7; i++) rd(16'(i * 4));
  endtask

  // Monitor: compares whatever the DUT presents against the queued expectations.
  logic pend = 1'b0;
  logic saw_wait = 1'b0;
  always @(negedge clk) begin
    resp_t      e;
    logic [2:0] ie;
    if (mon_en) begin
      if (irq_q.size() > 0) begin
        ie = irq_q.pop_front();
        check("timer_irq", timer_irq, ie[2]);
        check("soft_irq", soft_irq, ie[1:0]);
      end
      if (pend) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL scoreboard: data phase seen with no expected response");
          pend = 1'b0;
        end else if (!hready_resp) begin
          check("hready_resp_wait", hready_resp, exp_q[0].err ? 1'b0 : 1'b1);
          check("hresp_err_cycle1", hresp, 1'b1);
          check("hrdata_err_cycle1", hrdata, 32'd0);
          saw_wait = 1'b1;
        end else begin
          e = exp_q.pop_front();
          check("hresp", hresp, e.err);
          if (e.err) begin
            check("err_two_cycles", saw_wait, 1'b1);
            check("hrdata_err_cycle2", hrdata, 32'd0);
          end else if (e.chk) begin
            check("hrdata", hrdata, e.data);
          end
          pend = 1'b0;
          saw_wait = 1'b0;
        end
      end else begin
        check("idle_hready_resp", hready_resp, 1'b1);
        check("idle_hresp", hresp, 1'b0);
        check("idle_hrdata", hrdata, 32'd0);
      end
      if (rst) begin
        pend = 1'b0;
        saw_wait = 1'b0;
        exp_q.delete();
      end else if (hready && htrans[1]) begin
        pend = 1'b1;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  idx;
    logic [2:0]  sz;
    logic [15:0] a;
    logic [31:0] wd;
    logic        w;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    model_reset();
    idle(2);

    rd_all();
    idle(1);

    wr(16'h04, 32'd3);
    wr(16'h00, 32'd1);
    idle(40);
    rd(16'h08);
    rd(16'h0C);
    idle(2);

    wr(16'h14, 32'd0);
    wr(16'h10, 32'd5);
    wr(16'h04, 32'd0);
    wr(16'h08, 32'd0);
    idle(10);
    wr(16'h10, 32'hffff_ffff);
    idle(3);
    wr(16'h14, 32'hffff_ffff);

    wr(16'h00, 32'd0);
    wr(16'h08, 32'hffff_ffff);
    wr(16'h0C, 32'd0);
    wr(16'h00, 32'd1);
    rd(16'h08);
    rd(16'h0C);
    wr(16'h00, 32'd0);
    wr(16'h0C, 32'hffff_ffff);
    wr(16'h08, 32'hffff_ffff);
    wr(16'h00, 32'd1);
    rd(16'h08);
    rd(16'h0C);
    idle(2);

    xfer(16'h18, 1'b1, 3'd0, 32'd3);
    xfer(16'h02, 1'b0, 3'd2, 32'd0);
    xfer(16'h1C, 1'b0, 3'd2, 32'd0);
    xfer(16'h1C, 1'b1, 3'd2, 32'd1);
    rd(16'h18);
    idle(1);

    wr(16'h18, 32'd2);
    idle(2);
    wr(16'h18, 32'd1);
    rd(16'h18);
    idle(2);

    step(mk(16'h1C, 1'b0, 3'd2, 32'd0), 16'h1C, 3'd2, 1'b0);
    step('0, 16'h0, 3'd2, 1'b1);
    idle(2);
    rd_all();
    idle(2);

    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 9) < 2) begin
        idle(1);
      end else begin
        idx = 3'($urandom_range(0, 7));
        w   = 1'($urandom_range(0, 1));
        sz  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'd2;
        a   = 16'({idx, 2'b00});
        if ($urandom_range(0, 9) == 0) a[1:0] = 2'($urandom_range(1, 3));
        case (idx)
          3'd0:    wd = ($urandom_range(0, 3) != 0) ? 32'd1 : 32'd0;
          3'd1:    wd = 32'($urandom_range(0, 3));
          3'd2:    wd = 32'($urandom_range(0, 40));
          3'd3:    wd = ($urandom_range(0, 7) == 0) ? 32'hffff_ffff : 32'd0;
          3'd4:    wd = 32'($urandom_range(0, 60));
          3'd5:    wd = ($urandom_range(0, 3) == 0) ? $urandom : 32'd0;
          default: wd = $urandom;
        endcase
        xfer(a, w, sz, wd);
      end
    end
    idle(4);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
